apb_master: RTL and testbench

APB requester that converts a simple valid/ready command channel into APB transfers. It drives the same APB slave interface our peripherals (UART, etc.) expose on the peripheral bus. It issues one transfer at a time, waits on pready, and returns read data and error status on a valid/ready response channel. It is used by the debug/DMA side to reach peripheral registers and includes a timeout guard against hung slaves.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_timeout_ctr.sv | 38 +++
 rtl/apb_master.sv | 125 ++++++++++++
 tb/tb_apb_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, command/response records
// and the default bus widths used by the peripheral bus.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int STRB_W     = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [STRB_W-1:0]     strb;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles of the current transfer and flags the cycle in which
// the slave has used up its allowance. TIMEOUT = 0 removes the guard.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int            CW   = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_reg;

      // Cycle counter: cleared per transfer, saturates on the final cycle
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // Expiry is flagged during the ACCESS cycle that reaches TIMEOUT-1
      assign expired = enable && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time from a valid/ready channel, drives a
// full SETUP/ACCESS transfer, returns read data / error on a response channel.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_state_e state_reg;
  logic       accept;
  logic       in_access;
  logic       expired;

  assign accept    = (state_reg == IDLE) && req_valid && req_ready;
  assign in_access = (state_reg == ACCESS);

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (accept),
    .enable  (in_access),
    .expired (expired)
  );

  // Transfer FSM; every bus and channel output is a register of this block
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pstrb     <= '0;
      pwdata    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // The APB output registers double as the command capture
            req_ready <= 1'b0;
            psel      <= 1'b1;
            paddr     <= req_addr;
            pwrite    <= req_write;
            pstrb     <= req_write ? req_strb : '0;
            pwdata    <= req_wdata;
            state_reg <= SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end

        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
        end

        ACCESS: begin
          // pready takes priority over an expiry in the same cycle
          if (pready || expired) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pstrb     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
            if (pready) begin
              rsp_rdata <= pwrite ? '0 : prdata;
              rsp_err   <= pslverr;
            end else begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: driver issues commands and queues the expected
// response, a scripted slave answers each transfer, a monitor scores responses.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_strb = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_strb  (req_strb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pstrb     (pstrb),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  // How the slave will behave for one transfer
  typedef struct {
    apb_req_t    cmd;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  plan_t    slave_q[$];
  apb_rsp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 1'b0;
  int bp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Queue the slave script and the expected response, then hand the command over
  task automatic send(input apb_req_t c, input int waits, input logic e,
                      input logic [31:0] rd, input bit expect_rsp);
    plan_t    p;
    apb_rsp_t r;
    int       n;
    p.cmd = c; p.waits = waits; p.err = e; p.rdata = rd;
    slave_q.push_back(p);
    if (expect_rsp) begin
      if (waits >= TO) begin
        r.err = 1'b1; r.rdata = 32'h0;
      end else begin
        r.err = e; r.rdata = c.write ? 32'h0 : rd;
      end
      exp_q.push_back(r);
    end
    @(negedge pclk);
    req_valid = 1'b1;
    req_addr  = c.addr;
    req_write = c.write;
    req_strb  = c.strb;
    req_wdata = c.wdata;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 300) bound_fail("req_accept");
    @(posedge pclk);
    #1;
    req_valid = 1'b0;
    $display("cmd  addr=%08h write=%0d strb=%0h wdata=%08h waits=%0d err=%0d", c.addr, c.write, c.strb, c.wdata, waits, e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || psel || rsp_valid) && n < 500) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 500) bound_fail("wait_idle");
    @(negedge pclk);
  endtask

  // Scripted APB slave; also checks bus protocol as seen from the slave side
  plan_t cur;
  bit    active = 1'b0;
  int    acc = 0;
  always @(negedge pclk) begin
    if (!presetn) begin
      active = 1'b0;
      pready = 1'b0;
      slave_q.delete();
    end else if (psel) begin
      if (!penable) begin
        if (!active) begin
          if (slave_q.size() == 0) bound_fail("unexpected_setup");
          else cur = slave_q.pop_front();
          active = 1'b1;
          acc = 0;
        end
        pready = 1'b0;
      end else begin
        acc++;
        if (acc == cur.waits + 1) begin
          pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
      end
      chk("paddr", paddr, cur.cmd.addr);
      chk("pwrite", pwrite, cur.cmd.write);
      chk("pstrb", pstrb, cur.cmd.write ? cur.cmd.strb : 4'h0);
      chk("pwdata", pwdata, cur.cmd.wdata);
    end else begin
      if (active) begin
        chk("access_cycles", acc, (cur.waits >= TO) ? TO : cur.waits + 1);
        active = 1'b0;
      end
      chk("idle_penable", penable, 0);
      chk("idle_paddr", paddr, 0);
      chk("idle_ctrl", {pwrite, pstrb}, 0);
      chk("idle_pwdata", pwdata, 0);
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  // Response monitor / scoreboard
  bit          hold = 1'b0;
  bit          rr_chk = 1'b0;
  logic [31:0] held_data;
  logic        held_err;
  apb_rsp_t    e_rsp;
  always @(negedge pclk) begin
    if (!presetn) begin
      hold = 1'b0; rr_chk = 1'b0; rsp_ready = 1'b0;
    end else begin
      if (rr_chk) begin
        chk("req_ready_after_rsp", req_ready, 1);
        rr_chk = 1'b0;
      end
      if (hold) begin
        chk("rsp_valid_held", rsp_valid, 1);
        chk("rsp_rdata_held", rsp_rdata, held_data);
        chk("rsp_err_held", rsp_err, held_err);
      end
      if (rsp_valid && bp_cnt > 0) begin
        rsp_ready = 1'b0;
        bp_cnt--;
        chk("bp_req_ready", req_ready, 0);
        chk("bp_psel", psel, 0);
      end else begin
        rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_response");
        end else begin
          e_rsp = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e_rsp.rdata);
          chk("rsp_err", rsp_err, e_rsp.err);
          $display("rsp  rdata=%08h err=%0d (exp %08h/%0d)", rsp_rdata, rsp_err, e_rsp.rdata, e_rsp.err);
        end
        rr_chk = 1'b1;
        hold = 1'b0;
      end else begin
        hold = rsp_valid; held_data = rsp_rdata; held_err = rsp_err;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apb_req_t c;
    int       n;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    #2 presetn = 1'b1;
    repeat (2) @(negedge pclk);
    chk("post_rst_req_ready", req_ready, 1);

    // Zero-wait write with cycle-exact latency
    c.addr = 32'h10; c.write = 1'b1; c.strb = 4'hF; c.wdata = 32'hDEADBEEF;
    send(c, 0, 1'b0, 32'h0, 1'b1);
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    chk("t1_setup_paddr", paddr, 32'h10);
    @(posedge pclk); #1;
    chk("t2_access_psel", psel, 1);
    chk("t2_access_penable", penable, 1);
    chk("t2_access_pwdata", pwdata, 32'hDEADBEEF);
    chk("t2_access_pstrb", pstrb, 4'hF);
    @(posedge pclk); #1;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_err", rsp_err, 0);
    chk("t3_rsp_rdata", rsp_rdata, 0);
    chk("t3_psel", psel, 0);
    wait_idle();

    // Read with two wait states
    c.addr = 32'h4; c.write = 1'b0; c.strb = 4'hF; c.wdata = 32'h0;
    send(c, 2, 1'b0, 32'h12345678, 1'b1);
    wait_idle();

    // Slave error on a write
    c.addr = 32'h8; c.write = 1'b1; c.strb = 4'h3; c.wdata = 32'hCAFE0001;
    send(c, 1, 1'b1, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // Timeout, then pready on the last allowed cycle, then a normal read
    c.addr = 32'h20; c.write = 1'b0; c.strb = 4'h0; c.wdata = 32'h0;
    send(c, 1000, 1'b0, 32'h11111111, 1'b1);
    wait_idle();
    c.addr = 32'h24;
    send(c, TO - 1, 1'b0, 32'h5A5A5A5A, 1'b1);
    wait_idle();
    c.addr = 32'h0;
    send(c, 0, 1'b0, 32'hA5, 1'b1);
    wait_idle();

    // Response backpressure
    bp_cnt = 5;
    c.addr = 32'h14; c.write = 1'b0; c.strb = 4'h0; c.wdata = 32'h0;
    send(c, 0, 1'b0, 32'h0BADF00D, 1'b1);
    wait_idle();
    chk("bp_applied", bp_cnt, 0);

    // Reset in the middle of ACCESS
    c.addr = 32'h18; c.write = 1'b1; c.strb = 4'hF; c.wdata = 32'h77777777;
    send(c, 3, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 50) bound_fail("reach_access");
    #2 presetn = 1'b0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    @(negedge pclk);
    @(negedge pclk);
    #2 presetn = 1'b1;
    repeat (2) @(negedge pclk);
    chk("arst_release_req_ready", req_ready, 1);
    repeat (6) @(negedge pclk);
    chk("arst_no_rsp", rsp_valid, 0);

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      c.addr  = {$urandom_range(0, 255), 2'b00};
      c.write = 1'($urandom_range(0, 1));
      c.strb  = 4'($urandom_range(0, 15));
      c.wdata = $urandom;
      send(c, $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom, 1'b1);
    end
    wait_idle();
    chk("slave_q_drained", slave_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
